// File: rtl/pt_pkg.sv
// Shared constants, symbol codes and FSM state type for the PT2262-style
// tri-state frame encoder.
package pt_pkg;

  localparam int A_SHORT  = 4;
  localparam int A_LONG   = 12;
  localparam int A_SYNC_H = 4;
  localparam int A_SYNC_L = 124;

  localparam logic [1:0] SYM_0   = 2'b00;
  localparam logic [1:0] SYM_1   = 2'b11;
  localparam logic [1:0] SYM_F   = 2'b01;
  localparam logic [1:0] SYM_RSV = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BIT_H  = 3'd1,
    ST_BIT_L  = 3'd2,
    ST_SYNC_H = 3'd3,
    ST_SYNC_L = 3'd4
  } pt_state_e;

  // Length in alpha units of the given state; hb is the half-bit being sent.
  function automatic logic [6:0] unit_len(input pt_state_e st, input logic hb);
    case (st)
      ST_BIT_H:  unit_len = hb ? 7'(A_LONG) : 7'(A_SHORT);
      ST_BIT_L:  unit_len = hb ? 7'(A_SHORT) : 7'(A_LONG);
      ST_SYNC_H: unit_len = 7'(A_SYNC_H);
      ST_SYNC_L: unit_len = 7'(A_SYNC_L);
      default:   unit_len = 7'd1;
    endcase
  endfunction

endpackage

// File: rtl/pt_tick.sv
// Alpha prescaler: one-cycle tick every CLK_PER_A enabled clk cycles.
module pt_tick #(
  parameter int CLK_PER_A = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLK_PER_A > 1) ? $clog2(CLK_PER_A) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_PER_A - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/pt_enc_gen.sv
// Tri-state remote-control frame generator: latches a symbol word and repeat
// count on start, then emits pulse-width coded half-bits followed by a sync.
module pt_enc_gen
  import pt_pkg::*;
#(
  parameter int N_SYM     = 12,
  parameter int CLK_PER_A = 1,
  parameter int REP_W     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2*N_SYM-1:0] sym,
  input  logic [REP_W-1:0]   n_rep,
  input  logic               abort,
  output logic               q,
  output logic               busy,
  output logic               done,
  output logic               frame_end,
  output pt_state_e          dbg_state
);

  localparam int NHB = 2 * N_SYM;
  localparam int IW  = $clog2(NHB);
  localparam logic [IW-1:0] LAST_HB = IW'(NHB - 1);

  pt_state_e        state;
  logic [NHB-1:0]   sym_q;
  logic [REP_W-1:0] rep_cnt;
  logic [IW-1:0]    hb_idx;
  logic [6:0]       unit_cnt;
  logic             tick;
  logic             accept;
  logic             hb;
  logic             unit_last;

  // start is only looked at in IDLE, and a simultaneous abort wins.
  assign accept    = (state == ST_IDLE) && start && !abort;
  assign hb        = sym_q[LAST_HB - hb_idx];
  assign unit_last = (unit_cnt == unit_len(state, hb) - 7'd1);

  pt_tick #(.CLK_PER_A(CLK_PER_A)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    (busy),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      sym_q     <= '0;
      rep_cnt   <= '0;
      hb_idx    <= '0;
      unit_cnt  <= '0;
      done      <= 1'b0;
      frame_end <= 1'b0;
    end else begin
      done      <= 1'b0;
      frame_end <= 1'b0;
      if (abort && state != ST_IDLE) begin
        state    <= ST_IDLE;
        rep_cnt  <= '0;
        hb_idx   <= '0;
        unit_cnt <= '0;
      end else if (state == ST_IDLE) begin
        if (accept) begin
          state    <= ST_BIT_H;
          sym_q    <= sym;
          rep_cnt  <= (n_rep == '0) ? '0 : n_rep - 1'b1;
          hb_idx   <= '0;
          unit_cnt <= '0;
        end
      end else if (tick) begin
        if (!unit_last) begin
          unit_cnt <= unit_cnt + 7'd1;
        end else begin
          unit_cnt <= '0;
          case (state)
            ST_BIT_H: state <= ST_BIT_L;
            ST_BIT_L: begin
              if (hb_idx == LAST_HB) begin
                state <= ST_SYNC_H;
              end else begin
                hb_idx <= hb_idx + 1'b1;
                state  <= ST_BIT_H;
              end
            end
            ST_SYNC_H: state <= ST_SYNC_L;
            ST_SYNC_L: begin
              frame_end <= 1'b1;
              hb_idx    <= '0;
              if (rep_cnt != '0) begin
                rep_cnt <= rep_cnt - 1'b1;
                state   <= ST_BIT_H;
              end else begin
                done  <= 1'b1;
                state <= ST_IDLE;
              end
            end
            default: state <= ST_IDLE;
          endcase
        end
      end
    end
  end

  assign q         = (state == ST_BIT_H) || (state == ST_SYNC_H);
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_pt_enc_gen.sv
// Bench for pt_enc_gen: default instance (N_SYM=12, CLK_PER_A=1) and a small
// instance (N_SYM=4, CLK_PER_A=3), checked against a waveform-list model.
module tb_pt_enc_gen;
  import pt_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start_a = 1'b0, abort_a = 1'b0;
  logic [23:0] sym_a = '0;
  logic [3:0]  nrep_a = '0;
  logic        q_a, busy_a, done_a, fe_a;
  pt_state_e   st_a;

  logic        start_b = 1'b0, abort_b = 1'b0;
  logic [7:0]  sym_b = '0;
  logic [3:0]  nrep_b = '0;
  logic        q_b, busy_b, done_b, fe_b;
  pt_state_e   st_b;

  pt_enc_gen u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .sym(sym_a), .n_rep(nrep_a),
    .abort(abort_a), .q(q_a), .busy(busy_a), .done(done_a), .frame_end(fe_a),
    .dbg_state(st_a)
  );

  pt_enc_gen #(.N_SYM(4), .CLK_PER_A(3), .REP_W(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .sym(sym_b), .n_rep(nrep_b),
    .abort(abort_b), .q(q_b), .busy(busy_b), .done(done_b), .frame_end(fe_b),
    .dbg_state(st_b)
  );

  bit   sel = 1'b0;
  logic o_q, o_busy, o_done, o_fe;
  assign o_q    = sel ? q_b    : q_a;
  assign o_busy = sel ? busy_b : busy_a;
  assign o_done = sel ? done_b : done_a;
  assign o_fe   = sel ? fe_b   : fe_a;

  // ---------------- scoreboard ----------------
  logic [0:0] exp_q[$];
  logic [0:0] obs_hist[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference: the line level for every clk cycle of one frame, appended.
  task automatic build_frame(input int n_sym, input int cpa, input logic [31:0] s);
    for (int h = 2 * n_sym - 1; h >= 0; h--) begin
      int hi;
      hi = s[h] ? 12 : 4;
      repeat (hi * cpa) exp_q.push_back(1'b1);
      repeat ((16 - hi) * cpa) exp_q.push_back(1'b0);
    end
    repeat (4 * cpa) exp_q.push_back(1'b1);
    repeat (124 * cpa) exp_q.push_back(1'b0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_in(input bit s_sel, input logic st, input logic [31:0] s, input int nrep);
    if (s_sel) begin
      start_b = st; sym_b = s[7:0]; nrep_b = 4'(nrep);
    end else begin
      start_a = st; sym_a = s[23:0]; nrep_a = 4'(nrep);
    end
  endtask

  task automatic run_request(input bit s_sel, input logic [31:0] s, input int nrep,
                             output int busy_n, output int fe_n, output int done_n);
    int n_sym, cpa, reps, frame, total;
    int q_bad, b_bad, d_bad, f_bad;
    n_sym = s_sel ? 4 : 12;
    cpa   = s_sel ? 3 : 1;
    reps  = (nrep == 0) ? 1 : nrep;
    frame = (32 * n_sym + 128) * cpa;
    exp_q.delete();
    for (int r = 0; r < reps; r++) build_frame(n_sym, cpa, s);
    total = exp_q.size();
    sel = s_sel;
    busy_n = 0; fe_n = 0; done_n = 0;
    q_bad = 0; b_bad = 0; d_bad = 0; f_bad = 0;
    obs_hist.delete();
    @(posedge clk); #1;
    drive_in(s_sel, 1'b1, s, nrep);
    @(posedge clk); #1;
    // Scramble inputs while busy: the latched copies must rule.
    drive_in(s_sel, 1'b0, $urandom, $urandom_range(0, 15));
    for (int i = 1; i <= total + 1; i++) begin
      @(negedge clk);
      obs_hist.push_back(o_q);
      busy_n += int'(o_busy);
      fe_n   += int'(o_fe);
      done_n += int'(o_done);
      if (o_q !== ((i <= total) ? exp_q[i-1] : 1'b0)) q_bad++;
      if (o_busy !== 1'(i <= total)) b_bad++;
      if (o_done !== 1'(i == total + 1)) d_bad++;
      if (o_fe !== 1'(i > 1 && ((i - 1) % frame) == 0)) f_bad++;
    end
    check("q_stream_mismatches", q_bad, 0);
    check("busy_window_mismatches", b_bad, 0);
    check("done_position_mismatches", d_bad, 0);
    check("frame_end_position_mismatches", f_bad, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          s_sel;
    logic [31:0] s;
    int          nrep;
    int          exp_busy;
    int          exp_frames;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_n, fe_n, done_n, cnt, bad, dn, fn;
    logic [31:0] hs[3];

    vecs[0] = '{1'b0, 32'b101010101010101000000001, 1, 512, 1};
    vecs[1] = '{1'b1, 32'b01010101, 2, 1536, 2};
    vecs[2] = '{1'b0, 32'hFFFFFF, 0, 512, 1};
    vecs[3] = '{1'b1, 32'b10101010, 3, 2304, 3};
    vecs[4] = '{1'b0, 32'h000000, 2, 1024, 2};

    // reset state
    #12;
    check("reset_q_a", int'(q_a), 0);
    check("reset_busy_a", int'(busy_a), 0);
    check("reset_done_fe_a", int'(done_a) + int'(fe_a), 0);
    check("reset_state_a", int'(st_a), int'(ST_IDLE));
    check("reset_outputs_b", int'(q_b) + int'(busy_b) + int'(done_b) + int'(fe_b), 0);
    #10 rst_n = 1'b1;

    // abort alone in IDLE is a no-op (the next request must run normally)
    @(posedge clk); #1 abort_a = 1'b1;
    @(posedge clk); #1 abort_a = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_request(vecs[i].s_sel, vecs[i].s, vecs[i].nrep, busy_n, fe_n, done_n);
      check($sformatf("vec%0d_busy_len", i), busy_n, vecs[i].exp_busy);
      check($sformatf("vec%0d_frame_ends", i), fe_n, vecs[i].exp_frames);
      check($sformatf("vec%0d_dones", i), done_n, 1);
      if (i == 0) begin
        cnt = 0;
        for (int k = 0; k < 16; k++) cnt += int'(obs_hist[k]);
        check("vec0_first_halfbit_high_units", cnt, 12);
        check("vec0_q_cycle13_low", int'(obs_hist[12]), 0);
        cnt = 0;
        for (int k = 16; k < 32; k++) cnt += int'(obs_hist[k]);
        check("vec0_second_halfbit_high_units", cnt, 4);
        check("vec0_q_cycle21_low", int'(obs_hist[20]), 0);
      end
    end

    // randomized requests
    for (int r = 0; r < 4; r++) begin
      int nr;
      nr = $urandom_range(0, 2);
      run_request(1'b0, $urandom, nr, busy_n, fe_n, done_n);
      check("rand_a_frame_ends", fe_n, (nr == 0) ? 1 : nr);
    end
    for (int r = 0; r < 2; r++) begin
      int nr;
      nr = $urandom_range(0, 3);
      run_request(1'b1, $urandom, nr, busy_n, fe_n, done_n);
      check("rand_b_busy_len", busy_n, ((nr == 0) ? 1 : nr) * 768);
    end

    // abort at cycle 100
    sel = 1'b0;
    @(posedge clk); #1 drive_in(1'b0, 1'b1, $urandom, 1);
    @(posedge clk); #1 drive_in(1'b0, 1'b0, $urandom, 1);
    repeat (99) @(posedge clk);
    #1 abort_a = 1'b1;
    @(negedge clk);
    check("abort_busy_cycle100", int'(busy_a), 1);
    @(posedge clk); #1 abort_a = 1'b0;
    @(negedge clk);
    check("abort_q_cycle101", int'(q_a), 0);
    check("abort_busy_cycle101", int'(busy_a), 0);
    dn = int'(done_a); fn = int'(fe_a);
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      dn += int'(done_a); fn += int'(fe_a);
    end
    check("abort_no_done_or_frame_end", dn + fn, 0);
    run_request(1'b0, $urandom, 1, busy_n, fe_n, done_n);
    check("after_abort_busy_len", busy_n, 512);

    // abort with start in the same IDLE cycle drops the start
    @(posedge clk); #1 start_a = 1'b1; abort_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0; abort_a = 1'b0;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      cnt += int'(busy_a);
    end
    check("abort_start_dropped_busy", cnt, 0);

    // start held high for three requests, sym scrambled mid-frame
    for (int k = 0; k < 3; k++) hs[k] = $urandom;
    exp_q.delete();
    for (int k = 0; k < 3; k++) begin
      build_frame(12, 1, hs[k]);
      exp_q.push_back(1'b0);
    end
    bad = 0; dn = 0; fn = 0;
    @(posedge clk); #1 drive_in(1'b0, 1'b1, hs[0], 0);
    @(posedge clk); #1;
    for (int i = 1; i <= 3 * 513; i++) begin
      int j, k;
      j = (i - 1) % 513;
      k = (i - 1) / 513;
      @(negedge clk);
      if (q_a !== exp_q[i-1]) bad++;
      if (busy_a !== 1'(j < 512)) bad++;
      if (done_a !== 1'(j == 512)) bad++;
      if (fe_a !== 1'(j == 512)) bad++;
      dn += int'(done_a); fn += int'(fe_a);
      if (j == 100) sym_a = 24'($urandom);
      if (j == 502 && k < 2) sym_a = hs[k+1][23:0];
      if (j == 100 && k == 2) start_a = 1'b0;
    end
    check("held_start_mismatches", bad, 0);
    check("held_start_dones", dn, 3);
    check("held_start_frame_ends", fn, 3);

    // asynchronous reset in BIT_H
    @(posedge clk); #1 drive_in(1'b0, 1'b1, 32'hFFFFFF, 1);
    @(posedge clk); #1 drive_in(1'b0, 1'b0, 32'hFFFFFF, 1);
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_q_high", int'(q_a), 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_q", int'(q_a), 0);
    check("async_reset_outputs", int'(busy_a) + int'(done_a) + int'(fe_a), 0);
    @(negedge clk) rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      cnt += int'(q_a) + int'(busy_a) + int'(done_a) + int'(fe_a);
    end
    check("post_reset_outputs_quiet", cnt, 0);
    run_request(1'b0, $urandom, 1, busy_n, fe_n, done_n);
    check("post_reset_busy_len", busy_n, 512);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
